i2c_target_regbank: RTL and testbench
=====================================

// Module: i2c_target_regbank
// PURPOSE
//  Next-generation I2C target: oversampled on one system clock (no SCL-clocked logic), parametrised
//  address, register-bank depth and input filtering, with full START/repeated-START/STOP handling
//  and a local host port. Sits between the open-drain pad wrapper and on-chip control logic.
//  Pointer auto-increments with wrap; every I2C write is reported to the host as a one-cycle event.
// PARAMETERS
//  TARGET_ADDR  7'h42  7-bit I2C address this block acknowledges
//  PTR_W        8      register pointer width; bank depth = 2**PTR_W bytes
//  SYNC_STAGES  2      flops in the SCL/SDA synchronisers (>=2)
//  FILT_LEN     3      consecutive equal samples before a filtered SCL/SDA level changes (>=1)
// PORTS
//  clk            in   1      system clock, >=10x SCL rate
//  resetn         in   1      asynchronous active-low reset
//  scl_i          in   1      raw SCL from pad
//  sda_i          in   1      raw SDA from pad
//  sda_drive_low  out  1      1 = pull SDA low; 0 = release (pad pull-up)
//  host_we        in   1      local write strobe
//  host_addr      in   PTR_W  local read/write index
//  host_wdata     in   8      local write data
//  host_rdata     out  8      bank[host_addr], combinational
//  wr_evt         out  1      one-cycle pulse: I2C wrote a bank byte
//  wr_evt_addr    out  PTR_W  index written (valid with wr_evt)
//  wr_evt_data    out  8      byte written (valid with wr_evt)
//  busy           out  1      1 from address ACK until STOP/START/NACK return to IDLE
// BEHAVIOUR
//  Reset: sda_drive_low=0, wr_evt=0, wr_evt_addr=0, wr_evt_data=0, busy=0, ptr=0, all bank bytes 0,
//   state IDLE, bit_cnt=0, filtered SCL/SDA=1. Reset mid-transfer releases SDA immediately.
//  Conditioning: sync -> filter -> edge detect; scl_rise/scl_fall/start/stop are 1-cycle pulses.
//   START = filt SDA 1->0 while filt SCL=1; STOP = filt SDA 0->1 while filt SCL=1.
//  SDA sampled on scl_rise, MSB first; sda_drive_low changes only on the cycle after scl_fall.
//  START in any state (incl. repeated START) -> ADDR, bit_cnt=0, SDA released. STOP in any state -> IDLE.
//  States:
//   IDLE       wait START.
//   ADDR       8 bits in; on 8th rise: addr match -> ADDR_ACK, else -> WAIT_STOP (no ACK driven).
//   ADDR_ACK   drive low for ACK bit; R/W=0 -> PTR, R/W=1 -> RDATA (shift reg loaded with bank[ptr]).
//   PTR        8 bits in -> PTR_ACK; ptr <= received byte on 8th rise.
//   PTR_ACK    drive ACK -> WDATA.
//   WDATA      8 bits in; on 8th rise bank[ptr]<=byte, wr_evt pulses with old ptr, ptr<=ptr+1 -> WDATA_ACK.
//   WDATA_ACK  drive ACK -> WDATA (unbounded burst).
//   RDATA      drive bit n after each fall (drive_low = ~bit); after 8th bit release SDA; ptr<=ptr+1 -> RDATA_ACK.
//   RDATA_ACK  sample master bit on rise: 0 (ACK) -> RDATA, reload bank[ptr]; 1 (NACK) -> WAIT_STOP.
//   WAIT_STOP  SDA released; only START/STOP leave.
//  ptr arithmetic modulo 2**PTR_W: 0xFF+1 -> 0x00 at PTR_W=8.
//  busy=1 in ADDR_ACK..RDATA_ACK; 0 in IDLE, ADDR, WAIT_STOP.
//  Host write and I2C write to same index in same cycle: I2C wins, wr_evt still fires.
//  Host write to bank[ptr] after RDATA reload does not alter the byte in flight.
//  Glitches shorter than FILT_LEN clk cycles on SCL or SDA are ignored (no edge, no START/STOP).
//  ADDR_ACK/PTR_ACK/WDATA_ACK drive low from the fall after the 8th bit to the next fall, then release.
// TESTING
//  1 Reset mid-read (SDA held low) -> sda_drive_low=0 same cycle, busy=0, bank all 0.
//  2 S,0x84,0x10,0xAA,0x55,P -> three ACKs, bank[0x10]=0xAA, bank[0x11]=0x55, wr_evt x2, ptr=0x12.
//  3 S,0x84,0xFF,0x01,0x02,P -> bank[0xFF]=0x01, bank[0x00]=0x02 (wrap), wr_evt_addr 0xFF then 0x00.
//  4 S,0x84,0x10,Sr,0x85, read 2 bytes ACK then NACK, P -> returns 0xAA,0x55; SDA released at NACK.
//  5 S,0x86 (wrong addr),P -> no ACK (SDA never driven), busy=0 throughout, bank unchanged.
//  6 2-clk SDA low pulse while SCL high (FILT_LEN=3) in IDLE -> no START, state stays IDLE.

Source files
------------

// File: rtl/i2c_target_regbank_if.sv
`timescale 1ns/1ps
// Host-side bus of the I2C target register bank: local read/write port plus
// the write-event report that the I2C side raises for every byte it stores.
interface i2c_target_regbank_if #(
   parameter int unsigned PTR_W = 8
);
   logic             host_we;
   logic [PTR_W-1:0] host_addr;
   logic [7:0]       host_wdata;
   logic [7:0]       host_rdata;
   logic             wr_evt;
   logic [PTR_W-1:0] wr_evt_addr;
   logic [7:0]       wr_evt_data;

   modport master (
      output host_we, host_addr, host_wdata,
      input  host_rdata, wr_evt, wr_evt_addr, wr_evt_data
   );

   modport slave (
      input  host_we, host_addr, host_wdata,
      output host_rdata, wr_evt, wr_evt_addr, wr_evt_data
   );
endinterface

// File: rtl/i2c_target_regbank.sv
`timescale 1ns/1ps
// I2C target with a byte-wide register bank. SCL/SDA are oversampled on clk
// (synchroniser -> glitch filter -> edge detect); no logic is clocked by SCL.
module i2c_target_regbank #(
   parameter logic [6:0]  TARGET_ADDR = 7'h42,
   parameter int unsigned PTR_W       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 3
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                scl_i,
   input  logic                sda_i,
   output logic                sda_drive_low,
   output logic                busy,
   i2c_target_regbank_if.slave host
);
   localparam int unsigned DEPTH = 2 ** PTR_W;
   localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

   typedef enum logic [3:0] {
      StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
      StWdata, StWdataAck, StRdata, StRdataAck, StWaitStop
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic [1:0]             raw, filt, filt_prev;   // bit 1 = SCL, bit 0 = SDA
   logic [CNT_W-1:0]       filt_cnt [2];
   logic                   scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;

   state_t                 state;
   logic [3:0]             bit_cnt;
   logic [7:0]             shift;
   logic [7:0]             rx_byte;
   logic                   rw;
   logic [PTR_W-1:0]       ptr;
   logic [7:0]             bank [DEPTH];

   // Synchronise the raw pad inputs; idle bus level is high.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         scl_sync <= '1;
         sda_sync <= '1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      end
   end

   assign raw = {scl_sync[SYNC_STAGES-1], sda_sync[SYNC_STAGES-1]};

   // Filter: a level change is accepted only after FILT_LEN consecutive differing samples.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         filt      <= 2'b11;
         filt_prev <= 2'b11;
         for (int i = 0; i < 2; i++) filt_cnt[i] <= '0;
      end else begin
         filt_prev <= filt;
         for (int i = 0; i < 2; i++) begin
            if (raw[i] == filt[i]) begin
               filt_cnt[i] <= '0;
            end else if (filt_cnt[i] == CNT_W'(FILT_LEN - 1)) begin
               filt[i]     <= raw[i];
               filt_cnt[i] <= '0;
            end else begin
               filt_cnt[i] <= filt_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign scl_f     = filt[1];
   assign sda_f     = filt[0];
   assign scl_rise  = scl_f & ~filt_prev[1];
   assign scl_fall  = ~scl_f & filt_prev[1];
   assign start_det = filt_prev[0] & ~sda_f & scl_f;
   assign stop_det  = ~filt_prev[0] & sda_f & scl_f;
   assign rx_byte   = {shift[6:0], sda_f};

   // Protocol FSM; all outputs are registered so SDA only moves the cycle after a fall.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state            <= StIdle;
         bit_cnt          <= '0;
         shift            <= '0;
         rw               <= 1'b0;
         ptr              <= '0;
         sda_drive_low    <= 1'b0;
         busy             <= 1'b0;
         host.wr_evt      <= 1'b0;
         host.wr_evt_addr <= '0;
         host.wr_evt_data <= '0;
      end else begin
         host.wr_evt <= 1'b0;
         if (stop_det) begin
            state         <= StIdle;
            bit_cnt       <= '0;
            sda_drive_low <= 1'b0;
            busy          <= 1'b0;
         end else if (start_det) begin
            state         <= StAddr;
            bit_cnt       <= '0;
            sda_drive_low <= 1'b0;
            busy          <= 1'b0;
         end else begin
            unique case (state)
               StIdle, StWaitStop: ;
               StAddr: if (scl_rise) begin
                  shift   <= rx_byte;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt <= '0;
                     if (rx_byte[7:1] == TARGET_ADDR) begin
                        state <= StAddrAck;
                        rw    <= rx_byte[0];
                        busy  <= 1'b1;
                     end else begin
                        state <= StWaitStop;
                     end
                  end
               end
               // First fall asserts ACK, second fall ends it and starts the next phase.
               StAddrAck: if (scl_fall) begin
                  if (!sda_drive_low) begin
                     sda_drive_low <= 1'b1;
                  end else if (rw) begin
                     state         <= StRdata;
                     bit_cnt       <= '0;
                     shift         <= {bank[ptr][6:0], 1'b0};
                     sda_drive_low <= ~bank[ptr][7];
                  end else begin
                     state         <= StPtr;
                     sda_drive_low <= 1'b0;
                  end
               end
               StPtr: if (scl_rise) begin
                  shift   <= rx_byte;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt <= '0;
                     ptr     <= PTR_W'(rx_byte);
                     state   <= StPtrAck;
                  end
               end
               StPtrAck, StWdataAck: if (scl_fall) begin
                  if (!sda_drive_low) begin
                     sda_drive_low <= 1'b1;
                  end else begin
                     sda_drive_low <= 1'b0;
                     state         <= StWdata;
                  end
               end
               StWdata: if (scl_rise) begin
                  shift   <= rx_byte;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt          <= '0;
                     host.wr_evt      <= 1'b1;
                     host.wr_evt_addr <= ptr;
                     host.wr_evt_data <= rx_byte;
                     ptr              <= ptr + PTR_W'(1);
                     state            <= StWdataAck;
                  end
               end
               // bit_cnt counts master rises; shift holds the bits still to drive.
               StRdata: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        bit_cnt       <= '0;
                        sda_drive_low <= 1'b0;
                        ptr           <= ptr + PTR_W'(1);
                        state         <= StRdataAck;
                     end else begin
                        sda_drive_low <= ~shift[7];
                        shift         <= {shift[6:0], 1'b0};
                     end
                  end
               end
               StRdataAck: if (scl_rise) begin
                  if (!sda_f) begin
                     state <= StRdata;
                     shift <= bank[ptr];
                  end else begin
                     state <= StWaitStop;
                     busy  <= 1'b0;
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

   // Bank storage; the I2C write is applied last so it wins a same-index collision.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      end else begin
         if (host.host_we) bank[host.host_addr] <= host.host_wdata;
         if (host.wr_evt)  bank[host.wr_evt_addr] <= host.wr_evt_data;
      end
   end

   assign host.host_rdata = bank[host.host_addr];
endmodule

// File: tb/tb_i2c_target_regbank.sv
`timescale 1ns/1ps
// Bench for i2c_target_regbank: bit-banged I2C master, transaction-level bank model,
// address-byte vector table, directed corner cases and randomized traffic.
module tb_i2c_target_regbank;
   localparam int Q = 8;  // clk cycles per quarter SCL period

   typedef struct {
      logic [7:0] addr_byte;
      logic       exp_ack;
   } addr_vec_t;

   logic clk = 1'b0;
   logic resetn;
   logic scl_m, sda_m;
   logic sda_drive_low, busy;
   logic sda_line;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] bank_m [256];
   logic [7:0] ptr_m;
   logic [15:0] evt_log [$];
   int         drive_cycles = 0;
   int         busy_cycles = 0;

   assign sda_line = sda_m & ~sda_drive_low;

   i2c_target_regbank_if #(.PTR_W(8)) bus ();

   i2c_target_regbank #(
      .TARGET_ADDR(7'h42),
      .PTR_W(8),
      .SYNC_STAGES(2),
      .FILT_LEN(3)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .scl_i(scl_m),
      .sda_i(sda_line),
      .sda_drive_low(sda_drive_low),
      .busy(busy),
      .host(bus)
   );

   always #5 clk = ~clk;

   // Observe drive/busy activity and log every write event.
   always @(negedge clk) begin
      if (sda_drive_low) drive_cycles <= drive_cycles + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
      if (bus.wr_evt) evt_log.push_back({bus.wr_evt_addr, bus.wr_evt_data});
   end

   initial begin
      #4_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "simulation did not finish");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic clock_bit(input logic b, output logic seen);
      sda_m = b;
      tick(Q);
      scl_m = 1'b1;
      tick(Q);
      seen = sda_line;
      tick(Q);
      scl_m = 1'b0;
      tick(Q);
   endtask

   task automatic i2c_start;
      sda_m = 1'b1;
      tick(Q);
      scl_m = 1'b1;
      tick(Q);
      sda_m = 1'b0;
      tick(Q);
      scl_m = 1'b0;
      tick(Q);
   endtask

   task automatic i2c_stop;
      sda_m = 1'b0;
      tick(Q);
      scl_m = 1'b1;
      tick(Q);
      sda_m = 1'b1;
      tick(2 * Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
      clock_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         d[i] = s;
      end
      clock_bit(nack, s);
   endtask

   task automatic host_write(input logic [7:0] a, input logic [7:0] d);
      bus.host_we    = 1'b1;
      bus.host_addr  = a;
      bus.host_wdata = d;
      tick(1);
      bus.host_we = 1'b0;
      bank_m[a] = d;
   endtask

   task automatic host_check(input string nm, input logic [7:0] a);
      bus.host_addr = a;
      #1;
      check(nm, bus.host_rdata, bank_m[a]);
      tick(1);
   endtask

   // Write transaction: set pointer, then n data bytes; events and bank contents follow the model.
   task automatic i2c_write(input string nm, input logic [7:0] p, input int n,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
      logic       ack;
      logic [7:0] d [3];
      int         base;
      d[0] = d0;
      d[1] = d1;
      d[2] = d2;
      base = evt_log.size();
      i2c_start;
      write_byte(8'h84, ack);
      check({nm, "_addr_ack"}, ack, 1'b1);
      write_byte(p, ack);
      check({nm, "_ptr_ack"}, ack, 1'b1);
      ptr_m = p;
      for (int i = 0; i < n; i++) begin
         write_byte(d[i], ack);
         check({nm, "_data_ack"}, ack, 1'b1);
      end
      i2c_stop;
      check({nm, "_evt_count"}, evt_log.size() - base, n);
      for (int i = 0; i < n; i++) begin
         if (base + i < evt_log.size()) check({nm, "_evt"}, evt_log[base + i], {ptr_m, d[i]});
         bank_m[ptr_m] = d[i];
         host_check({nm, "_bank"}, ptr_m);
         ptr_m = ptr_m + 8'd1;
      end
   endtask

   // Read transaction of n bytes (last one NACKed), optionally setting the pointer first.
   task automatic i2c_read(input string nm, input logic set_ptr, input logic [7:0] p, input int n);
      logic       ack;
      logic [7:0] d;
      if (set_ptr) begin
         i2c_start;
         write_byte(8'h84, ack);
         check({nm, "_waddr_ack"}, ack, 1'b1);
         write_byte(p, ack);
         check({nm, "_ptr_ack"}, ack, 1'b1);
         ptr_m = p;
      end
      i2c_start;
      write_byte(8'h85, ack);
      check({nm, "_raddr_ack"}, ack, 1'b1);
      for (int i = 0; i < n; i++) begin
         read_byte(i == n - 1, d);
         check({nm, "_rdata"}, d, bank_m[ptr_m]);
         ptr_m = ptr_m + 8'd1;
      end
      check({nm, "_nack_release"}, sda_drive_low, 1'b0);
      check({nm, "_nack_busy"}, busy, 1'b0);
      i2c_stop;
   endtask

   initial begin
      addr_vec_t  avec [6];
      logic       ack, s, hit;
      logic [7:0] d, p;
      int         op, n, dc, bc, ev, nz;

      avec[0] = '{8'h84, 1'b1};
      avec[1] = '{8'h85, 1'b1};
      avec[2] = '{8'h86, 1'b0};
      avec[3] = '{8'h04, 1'b0};
      avec[4] = '{8'hC5, 1'b0};
      avec[5] = '{8'h8C, 1'b0};

      for (int i = 0; i < 256; i++) bank_m[i] = 8'h00;
      ptr_m          = 8'h00;
      resetn         = 1'b0;
      scl_m          = 1'b1;
      sda_m          = 1'b1;
      bus.host_we    = 1'b0;
      bus.host_addr  = 8'h00;
      bus.host_wdata = 8'h00;
      tick(3);
      check("rst_sda", sda_drive_low, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_wr_evt", bus.wr_evt, 1'b0);
      check("rst_evt_addr", bus.wr_evt_addr, 8'h00);
      check("rst_evt_data", bus.wr_evt_data, 8'h00);
      resetn = 1'b1;
      tick(10);
      host_check("rst_bank0", 8'h00);
      host_check("rst_bankff", 8'hFF);

      // Burst write with auto-increment, then a pointer-less read proves ptr ended at 0x12.
      host_write(8'h12, 8'h3E);
      i2c_write("t2", 8'h10, 2, 8'hAA, 8'h55, 8'h00);
      i2c_read("t2_ptr", 1'b0, 8'h00, 1);

      // Pointer wrap 0xFF -> 0x00.
      i2c_write("t3", 8'hFF, 2, 8'h01, 8'h02, 8'h00);

      // Repeated START into a two-byte read.
      i2c_read("t4", 1'b1, 8'h10, 2);

      // Wrong address: no ACK, never driven, never busy, no bank change.
      dc = drive_cycles;
      bc = busy_cycles;
      ev = evt_log.size();
      i2c_start;
      write_byte(8'h86, ack);
      i2c_stop;
      check("t5_nack", ack, 1'b0);
      check("t5_no_drive", drive_cycles - dc, 0);
      check("t5_no_busy", busy_cycles - bc, 0);
      check("t5_no_evt", evt_log.size() - ev, 0);
      host_check("t5_bank", 8'h10);

      // 2-clk SDA low pulse while SCL high must not register as START.
      tick(5);
      dc = drive_cycles;
      bc = busy_cycles;
      sda_m = 1'b0;
      tick(2);
      sda_m = 1'b1;
      scl_m = 1'b0;
      tick(Q);
      for (int i = 7; i >= 0; i--) begin
         d = 8'h84;
         clock_bit(d[i], s);
      end
      clock_bit(1'b1, s);
      check("t6_no_ack", s, 1'b1);
      check("t6_no_drive", drive_cycles - dc, 0);
      check("t6_no_busy", busy_cycles - bc, 0);
      i2c_stop;

      // Address-byte table.
      for (int i = 0; i < 6; i++) begin
         i2c_start;
         write_byte(avec[i].addr_byte, ack);
         check($sformatf("avec%0d_ack", i), ack, avec[i].exp_ack);
         if (ack && avec[i].exp_ack && avec[i].addr_byte[0]) begin
            read_byte(1'b1, d);
            check($sformatf("avec%0d_rdata", i), d, bank_m[ptr_m]);
            ptr_m = ptr_m + 8'd1;
         end
         i2c_stop;
         check($sformatf("avec%0d_busy", i), busy, 1'b0);
      end

      // Host and I2C write the same index in the same cycle: I2C value must stick.
      hit = 1'b0;
      fork
         i2c_write("collide", 8'h30, 1, 8'h5A, 8'h00, 8'h00);
         begin
            for (int k = 0; k < 4000 && !hit; k++) begin
               @(negedge clk);
               if (bus.wr_evt) begin
                  hit            = 1'b1;
                  bus.host_we    = 1'b1;
                  bus.host_addr  = 8'h30;
                  bus.host_wdata = 8'hC3;
                  @(negedge clk);
                  bus.host_we = 1'b0;
               end
            end
         end
      join
      check("collide_evt_seen", hit, 1'b1);

      // Host overwrite after reload must not change the byte already in flight.
      host_write(8'h40, 8'h11);
      i2c_start;
      write_byte(8'h84, ack);
      write_byte(8'h40, ack);
      ptr_m = 8'h40;
      i2c_start;
      write_byte(8'h85, ack);
      check("inflight_ack", ack, 1'b1);
      host_write(8'h40, 8'h99);
      read_byte(1'b1, d);
      check("inflight_data", d, 8'h11);
      ptr_m = 8'h41;
      i2c_stop;
      host_check("inflight_bank", 8'h40);

      // Randomized traffic against the model.
      for (int it = 0; it < 14; it++) begin
         op = $urandom_range(0, 2);
         n  = $urandom_range(1, 3);
         p  = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) p = 8'hFE;
         case (op)
            0: i2c_write("rnd_wr", p, n, 8'($urandom), 8'($urandom), 8'($urandom));
            1: i2c_read("rnd_rd", 1'($urandom_range(0, 1)), p, n);
            default: begin
               host_write(p, 8'($urandom));
               host_check("rnd_host", 8'($urandom_range(0, 255)));
            end
         endcase
      end

      // Reset in the middle of a read while the target is pulling SDA low.
      host_write(8'h20, 8'h3C);
      i2c_write("t1_ptr", 8'h20, 0, 8'h00, 8'h00, 8'h00);
      i2c_start;
      write_byte(8'h85, ack);
      check("t1_ack", ack, 1'b1);
      tick(1);
      check("t1_driving", sda_drive_low, 1'b1);
      check("t1_busy_before", busy, 1'b1);
      resetn = 1'b0;
      #1;
      check("t1_release", sda_drive_low, 1'b0);
      check("t1_busy", busy, 1'b0);
      tick(1);
      nz = 0;
      for (int i = 0; i < 256; i++) begin
         bus.host_addr = 8'(i);
         #1;
         if (bus.host_rdata !== 8'h00) nz++;
         tick(1);
      end
      check("t1_bank_clear", nz, 0);
      check("t1_evt_addr", bus.wr_evt_addr, 8'h00);
      scl_m = 1'b1;
      sda_m = 1'b1;
      tick(10);
      resetn = 1'b1;
      tick(10);
      for (int i = 0; i < 256; i++) bank_m[i] = 8'h00;
      ptr_m = 8'h00;
      i2c_write("post_rst", 8'h05, 1, 8'h66, 8'h00, 8'h00);
      i2c_read("post_rst", 1'b0, 8'h00, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
